// File: rtl/stage_memory0_arb_pkg.sv
// stage_memory0_arb_pkg: shared exception-cause encodings and helpers for memory stage 0.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stage_memory0_arb_pkg;

  // Exception causes carried down the pipe; misalign codes follow the RISC-V mcause values.
  typedef enum logic [3:0] {
    ECAUSE_NONE            = 4'd0,
    ECAUSE_ILLEGAL_INSN    = 4'd2,
    ECAUSE_LOAD_MISALIGN   = 4'd4,
    ECAUSE_LOAD_FAULT      = 4'd5,
    ECAUSE_STORE_MISALIGN  = 4'd6,
    ECAUSE_STORE_FAULT     = 4'd7,
    ECAUSE_LOAD_PAGE_FAULT = 4'd13
  } ecause_t;

  // Access width encoding on ex_mem_width.
  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  // True when the low address bits are not aligned to the access width.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    return ((width == WIDTH_HALF) && addr_lo[0]) ||
           ((width == WIDTH_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/stage_memory0_arb_if.sv
// stage_memory0_arb_if: execute, memory1, dcache and internal-requestor signals around memory stage 0.
// Latency: n/a (wiring only).
// Backpressure: mem0_stall towards execute, mem1_stall/dc_ready into the stage, req_grant to requestors.
interface stage_memory0_arb_if #(
  parameter int NREQ    = 2,
  parameter int PADDR_W = 27
);
  import stage_memory0_arb_pkg::*;

  // execute side
  logic                    ex_valid;
  logic                    ex_exc;
  ecause_t                 ex_exc_cause;
  logic [31:2]             ex_pc;
  logic [31:0]             ex_data0;
  logic [31:0]             ex_data1;
  logic                    ex_mem_read;
  logic                    ex_mem_write;
  logic                    ex_mem_extend;
  logic [1:0]              ex_mem_width;
  logic [4:0]              ex_wb_reg;
  logic                    mem0_stall;
  logic                    mem0_flush;

  // internal physical-address requestors
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*PADDR_W-1:0] req_addr;
  logic [NREQ-1:0]         req_grant;

  // dcache read port
  logic                    dc_ready;
  logic                    mem0_dc_read;
  logic                    mem0_dc_trans;
  logic [8:0]              mem0_dc_asid;
  logic [31:2]             mem0_dc_addr;
  logic [31:0]             csr_satp;

  // memory1 side and decode forwarding
  logic [31:0]             mem0_fwd_data;
  logic                    mem0_valid;
  logic                    mem0_exc;
  ecause_t                 mem0_exc_cause;
  logic [31:2]             mem0_pc;
  logic                    mem0_read;
  logic                    mem0_write;
  logic                    mem0_extend;
  logic [1:0]              mem0_width;
  logic [31:0]             mem0_addr;
  logic [31:0]             mem0_wdata;
  logic [4:0]              mem0_wb_reg;
  logic                    mem1_stall;

  // The stage itself.
  modport slave (
    input  ex_valid, ex_exc, ex_exc_cause, ex_pc, ex_data0, ex_data1,
           ex_mem_read, ex_mem_write, ex_mem_extend, ex_mem_width, ex_wb_reg,
           mem0_flush, req_valid, req_addr, dc_ready, csr_satp, mem1_stall,
    output mem0_stall, req_grant, mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr,
           mem0_fwd_data, mem0_valid, mem0_exc, mem0_exc_cause, mem0_pc, mem0_read,
           mem0_write, mem0_extend, mem0_width, mem0_addr, mem0_wdata, mem0_wb_reg
  );

  // The surrounding pipeline, requestors and dcache.
  modport master (
    output ex_valid, ex_exc, ex_exc_cause, ex_pc, ex_data0, ex_data1,
           ex_mem_read, ex_mem_write, ex_mem_extend, ex_mem_width, ex_wb_reg,
           mem0_flush, req_valid, req_addr, dc_ready, csr_satp, mem1_stall,
    input  mem0_stall, req_grant, mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr,
           mem0_fwd_data, mem0_valid, mem0_exc, mem0_exc_cause, mem0_pc, mem0_read,
           mem0_write, mem0_extend, mem0_width, mem0_addr, mem0_wdata, mem0_wb_reg
  );

endinterface

// File: rtl/stage_memory0_arb_rr_arbiter.sv
// stage_memory0_arb_rr_arbiter: picks the first asserted request at or after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is used and advances ptr.
module stage_memory0_arb_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan from ptr upwards (mod N) and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage_memory0_arb.sv
// stage_memory0_arb: memory-stage-0 pipeline register plus dcache read-port arbiter (optional MEM0_MISALIGN_EN).
// Latency: payload registered with 1 cycle latency; arbitration and dcache strobe are combinational.
// Backpressure: stalls execute on mem1_stall or a lost/blocked dcache access; requestors only see one-hot grants.
module stage_memory0_arb #(
  parameter int NREQ       = 2,
  parameter int PADDR_W    = 27,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_core,
  input  logic              reset_n,
  stage_memory0_arb_if.slave bus
);
  import stage_memory0_arb_pkg::*;

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // held instruction
  logic        valid_q;
  logic        exc_q;
  ecause_t     cause_q;
  logic [31:2] pc_q;
  logic        read_q;
  logic        write_q;
  logic        extend_q;
  logic [1:0]  width_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  wb_reg_q;

  // arbitration state
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_nxt;
  logic [3:0]       starve_cnt;
  logic [3:0]       starve_nxt;

  logic             need;
  logic             pipe_prio;
  logic             pipe_sel;
  logic             pipe_win;
  logic             int_win;
  logic             stall;
  logic [NREQ-1:0]  rr_grant;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_any;
  logic [PADDR_W-1:0] req_word;

  // values captured at load time
  logic             ld_exc;
  ecause_t          ld_cause;

  logic unused_satp;
  assign unused_satp = ^{bus.csr_satp[31], bus.csr_satp[21:0]};

  stage_memory0_arb_rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign need      = valid_q & (read_q | write_q) & ~exc_q;
  assign pipe_prio = (starve_cnt == 4'(STARVE_MAX));

  // Decide the dcache winner; nothing is granted while the dcache is busy.
  always_comb begin
    int_win  = 1'b0;
    pipe_sel = 1'b0;
    if (bus.dc_ready) begin
      if (need && pipe_prio) begin
        pipe_sel = 1'b1;
      end else if (rr_any) begin
        int_win = 1'b1;
      end else if (need) begin
        pipe_sel = 1'b1;
      end
    end
  end

  // A pipeline win is only useful if memory1 can take the access next cycle.
  assign pipe_win = pipe_sel & ~bus.mem1_stall;
  assign stall    = valid_q & ~bus.mem0_flush & (bus.mem1_stall | (need & ~pipe_win));

  // Select the granted requestor's word address (grant is one-hot).
  always_comb begin
    req_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_word = req_word | (bus.req_addr[i*PADDR_W +: PADDR_W] & {PADDR_W{rr_grant[i]}});
    end
  end

  // Drive the dcache port and requestor grants.
  always_comb begin
    bus.req_grant     = int_win ? rr_grant : '0;
    bus.mem0_dc_read  = int_win | pipe_win;
    bus.mem0_dc_trans = pipe_win;
    bus.mem0_dc_addr  = '0;
    if (pipe_win) begin
      bus.mem0_dc_addr = addr_q[31:2];
    end else if (int_win) begin
      bus.mem0_dc_addr = 30'(req_word);
    end
  end

  // Next round-robin pointer and starvation count.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    starve_nxt = starve_cnt;
    if (int_win) begin
      rr_ptr_nxt = (rr_idx == IDX_W'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
    end
    if (pipe_win || !need) begin
      starve_nxt = '0;
    end else if (int_win && !pipe_prio) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  // Exception status captured with the incoming instruction.
`ifdef MEM0_MISALIGN_EN
  logic misal;
  assign misal = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write) & ~bus.ex_exc &
                 misaligned(bus.ex_mem_width, bus.ex_data0[1:0]);

  always_comb begin
    ld_exc   = bus.ex_exc | misal;
    ld_cause = bus.ex_exc_cause;
    if (misal) begin
      ld_cause = bus.ex_mem_write ? ECAUSE_STORE_MISALIGN : ECAUSE_LOAD_MISALIGN;
    end
  end
`else
  always_comb begin
    ld_exc   = bus.ex_exc;
    ld_cause = bus.ex_exc_cause;
  end
`endif

  // Arbitration state registers.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      rr_ptr     <= rr_ptr_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Pipeline register: flush beats stall beats load.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      exc_q    <= 1'b0;
      cause_q  <= ECAUSE_NONE;
      pc_q     <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      extend_q <= 1'b0;
      width_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wb_reg_q <= '0;
    end else if (bus.mem0_flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q  <= bus.ex_valid;
      exc_q    <= ld_exc;
      cause_q  <= ld_cause;
      pc_q     <= bus.ex_pc;
      read_q   <= bus.ex_mem_read;
      write_q  <= bus.ex_mem_write;
      extend_q <= bus.ex_mem_extend;
      width_q  <= bus.ex_mem_width;
      addr_q   <= bus.ex_data0;
      wdata_q  <= bus.ex_data1;
      wb_reg_q <= bus.ex_wb_reg;
    end
  end

  assign bus.mem0_stall     = stall;
  assign bus.mem0_dc_asid   = bus.csr_satp[30:22];
  assign bus.mem0_fwd_data  = addr_q;
  assign bus.mem0_valid     = valid_q;
  assign bus.mem0_exc       = exc_q;
  assign bus.mem0_exc_cause = cause_q;
  assign bus.mem0_pc        = pc_q;
  assign bus.mem0_read      = read_q;
  assign bus.mem0_write     = write_q;
  assign bus.mem0_extend    = extend_q;
  assign bus.mem0_width     = width_q;
  assign bus.mem0_addr      = addr_q;
  assign bus.mem0_wdata     = wdata_q;
  assign bus.mem0_wb_reg    = wb_reg_q;

endmodule

// File: tb/tb_stage_memory0_arb.sv
// tb_stage_memory0_arb: directed vector table, corner-case sequences and a randomized run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stage_memory0_arb;
  import stage_memory0_arb_pkg::*;

  localparam int NREQ       = 2;
  localparam int PADDR_W    = 27;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  stage_memory0_arb_if #(.NREQ(NREQ), .PADDR_W(PADDR_W)) bus ();

  stage_memory0_arb #(.NREQ(NREQ), .PADDR_W(PADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_core (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ex_valid      = 1'b0;
    bus.ex_exc        = 1'b0;
    bus.ex_exc_cause  = ECAUSE_NONE;
    bus.ex_pc         = '0;
    bus.ex_data0      = '0;
    bus.ex_data1      = '0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_mem_write  = 1'b0;
    bus.ex_mem_extend = 1'b0;
    bus.ex_mem_width  = 2'd0;
    bus.ex_wb_reg     = 5'd0;
    bus.mem0_flush    = 1'b0;
    bus.req_valid     = '0;
    bus.dc_ready      = 1'b1;
    bus.mem1_stall    = 1'b0;
  endtask

  task automatic ex_mem(input logic rd, input logic wr, input logic [1:0] w, input logic [31:0] a);
    bus.ex_valid     = 1'b1;
    bus.ex_mem_read  = rd;
    bus.ex_mem_write = wr;
    bus.ex_mem_width = w;
    bus.ex_data0     = a;
    bus.ex_data1     = 32'hCAFE_0000 ^ a;
    bus.ex_pc        = 30'h100;
    bus.ex_wb_reg    = 5'd7;
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Runs a held load against two always-valid requestors; returns internal grants seen before the load wins.
  task automatic count_until_pipe(input string tag, input int exp_grants, input logic [29:0] exp_addr);
    int grants;
    bit won;
    grants = 0;
    won    = 0;
    for (int c = 0; c < 20 && !won; c++) begin
      @(negedge clk);
      if (bus.req_grant != '0) begin
        grants++;
        chk({tag, ".stall_while_losing"}, 64'(bus.mem0_stall), 64'd1);
      end else if (bus.mem0_dc_read && bus.mem0_dc_trans) begin
        won = 1;
        chk({tag, ".pipe_addr"}, 64'(bus.mem0_dc_addr), 64'(exp_addr));
        chk({tag, ".pipe_stall"}, 64'(bus.mem0_stall), 64'd0);
      end
      edge_step();
    end
    chk({tag, ".pipe_won"}, 64'(won), 64'd1);
    chk({tag, ".int_grants"}, 64'(grants), 64'(exp_grants));
  endtask

  // directed vector table
  typedef struct {
    logic        ex_valid, rd, wr;
    logic [31:0] addr;
    logic [1:0]  req;
    logic        dc_ready, m1s, flush;
    logic [1:0]  e_grant;
    logic        e_read, e_trans;
    logic [29:0] e_addr;
    logic        e_stall, e_valid;
  } vec_t;

  vec_t tbl[10];

  // reference model state
  typedef struct {
    logic        valid, exc, rd, wr, ext;
    logic [3:0]  cause;
    logic [29:0] pc;
    logic [1:0]  width;
    logic [31:0] addr, wdata;
    logic [4:0]  wb;
  } held_t;

  held_t m;
  int    m_rr;
  int    m_starve;

  // Winner by the arbitration rules: -1 none, NREQ the pipeline, otherwise a requestor index.
  function automatic int pick(input bit need, input logic [NREQ-1:0] rv, input bit ready);
    if (!ready) return -1;
    if (need && m_starve == STARVE_MAX) return NREQ;
    for (int k = 0; k < NREQ; k++) begin
      if (rv[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    if (need) return NREQ;
    return -1;
  endfunction

  task automatic random_cycle(input int cyc);
    bit need, pwin, iwin, exp_read, exp_stall, mis;
    int w;
    logic [63:0] exp_addr;
    logic [NREQ*PADDR_W-1:0] ra;
    held_t n;
    string s;
    s = $sformatf("rnd%0d", cyc);
    // stimulus
    bus.ex_valid      = ($urandom_range(0, 99) < 70);
    w                 = $urandom_range(0, 2);
    bus.ex_mem_read   = (w == 0);
    bus.ex_mem_write  = (w == 1);
    bus.ex_mem_width  = 2'($urandom_range(0, 2));
    bus.ex_data0      = $urandom;
    bus.ex_data1      = $urandom;
    bus.ex_pc         = 30'($urandom);
    bus.ex_mem_extend = 1'($urandom);
    bus.ex_wb_reg     = 5'($urandom);
    bus.ex_exc        = ($urandom_range(0, 9) == 0);
    case ($urandom_range(0, 3))
      0: bus.ex_exc_cause = ECAUSE_ILLEGAL_INSN;
      1: bus.ex_exc_cause = ECAUSE_LOAD_FAULT;
      2: bus.ex_exc_cause = ECAUSE_STORE_FAULT;
      default: bus.ex_exc_cause = ECAUSE_LOAD_PAGE_FAULT;
    endcase
    bus.mem0_flush = ($urandom_range(0, 99) < 8);
    bus.req_valid  = NREQ'(($urandom_range(0, 99) < 40) ? 1 : 0) |
                     NREQ'(($urandom_range(0, 99) < 40) ? 2 : 0);
    bus.req_addr   = {27'($urandom), 27'($urandom)};
    bus.dc_ready   = ($urandom_range(0, 99) < 80);
    bus.mem1_stall = ($urandom_range(0, 99) < 20);
    bus.csr_satp   = $urandom;
    @(negedge clk);
    // expectations from the model
    need      = m.valid && (m.rd || m.wr) && !m.exc;
    w         = pick(need, bus.req_valid, bus.dc_ready);
    iwin      = (w >= 0) && (w < NREQ);
    pwin      = (w == NREQ) && !bus.mem1_stall;
    exp_read  = iwin || pwin;
    exp_stall = m.valid && !bus.mem0_flush && (bus.mem1_stall || (need && !pwin));
    ra        = bus.req_addr;
    exp_addr  = pwin ? 64'(m.addr >> 2) :
                iwin ? (64'(ra >> (w * PADDR_W)) & ((64'd1 << PADDR_W) - 1)) : 64'd0;
    chk({s, ".grant"}, 64'(bus.req_grant), iwin ? (64'd1 << w) : 64'd0);
    chk({s, ".dc_read"}, 64'(bus.mem0_dc_read), 64'(exp_read));
    if (exp_read) begin
      chk({s, ".dc_trans"}, 64'(bus.mem0_dc_trans), 64'(pwin));
      chk({s, ".dc_addr"}, 64'(bus.mem0_dc_addr), exp_addr);
    end
    chk({s, ".stall"}, 64'(bus.mem0_stall), 64'(exp_stall));
    chk({s, ".asid"}, 64'(bus.mem0_dc_asid), 64'((bus.csr_satp >> 22) & 32'h1FF));
    chk({s, ".valid"}, 64'(bus.mem0_valid), 64'(m.valid));
    if (m.valid) begin
      chk({s, ".addr"}, 64'(bus.mem0_addr), 64'(m.addr));
      chk({s, ".fwd"}, 64'(bus.mem0_fwd_data), 64'(m.addr));
      chk({s, ".wdata"}, 64'(bus.mem0_wdata), 64'(m.wdata));
      chk({s, ".exc"}, 64'(bus.mem0_exc), 64'(m.exc));
      chk({s, ".cause"}, 64'(bus.mem0_exc_cause), 64'(m.cause));
      chk({s, ".ctl"}, 64'({bus.mem0_read, bus.mem0_write, bus.mem0_extend, bus.mem0_width,
                            bus.mem0_wb_reg, bus.mem0_pc}),
          64'({m.rd, m.wr, m.ext, m.width, m.wb, m.pc}));
    end
    // model next state
    if (bus.mem0_flush) begin
      m.valid = 1'b0;
    end else if (!exp_stall) begin
      mis = 0;
`ifdef MEM0_MISALIGN_EN
      mis = bus.ex_valid && (bus.ex_mem_read || bus.ex_mem_write) && !bus.ex_exc &&
            ((bus.ex_mem_width == 2'd1 && (bus.ex_data0 % 2) != 0) ||
             (bus.ex_mem_width == 2'd2 && (bus.ex_data0 % 4) != 0));
`endif
      n.valid = bus.ex_valid;
      n.exc   = bus.ex_exc || mis;
      n.cause = mis ? (bus.ex_mem_write ? 4'd6 : 4'd4) : 4'(bus.ex_exc_cause);
      n.rd    = bus.ex_mem_read;
      n.wr    = bus.ex_mem_write;
      n.ext   = bus.ex_mem_extend;
      n.width = bus.ex_mem_width;
      n.pc    = bus.ex_pc;
      n.addr  = bus.ex_data0;
      n.wdata = bus.ex_data1;
      n.wb    = bus.ex_wb_reg;
      m = n;
    end
    if (iwin) m_rr = (w + 1) % NREQ;
    if (pwin || !need) m_starve = 0;
    else if (iwin) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    edge_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    bus.req_addr = {27'h0000222, 27'h0000111};
    bus.csr_satp = 32'h5AC0_1234;
    do_reset();

    // reset state
    @(negedge clk);
    chk("reset.valid", 64'(bus.mem0_valid), 64'd0);
    chk("reset.exc", 64'(bus.mem0_exc), 64'd0);
    chk("reset.cause", 64'(bus.mem0_exc_cause), 64'd0);
    chk("reset.addr", 64'(bus.mem0_addr), 64'd0);
    chk("reset.wdata_pc_wb", 64'({bus.mem0_wdata, bus.mem0_pc, bus.mem0_wb_reg}), 64'd0);
    chk("reset.stall", 64'(bus.mem0_stall), 64'd0);
    chk("reset.dc_read", 64'(bus.mem0_dc_read), 64'd0);
    edge_step();

    // ex_valid rd wr addr req rdy m1s flush | grant read trans dc_addr stall valid_next
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h1000, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 30'h0,   1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,    2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 30'h400, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,    2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 30'h111, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,    2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 30'h222, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,    2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 30'h111, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,    2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 30'h222, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,    2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 30'h0,   1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h1234, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 30'h0,   1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 30'h0,   1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h5000, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 30'h0,   1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      idle_in();
      if (tbl[i].ex_valid) ex_mem(tbl[i].rd, tbl[i].wr, 2'd2, tbl[i].addr);
      bus.req_valid  = tbl[i].req;
      bus.dc_ready   = tbl[i].dc_ready;
      bus.mem1_stall = tbl[i].m1s;
      bus.mem0_flush = tbl[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d.grant", i), 64'(bus.req_grant), 64'(tbl[i].e_grant));
      chk($sformatf("vec%0d.dc_read", i), 64'(bus.mem0_dc_read), 64'(tbl[i].e_read));
      if (tbl[i].e_read) begin
        chk($sformatf("vec%0d.dc_trans", i), 64'(bus.mem0_dc_trans), 64'(tbl[i].e_trans));
        chk($sformatf("vec%0d.dc_addr", i), 64'(bus.mem0_dc_addr), 64'(tbl[i].e_addr));
      end
      chk($sformatf("vec%0d.stall", i), 64'(bus.mem0_stall), 64'(tbl[i].e_stall));
      edge_step();
      chk($sformatf("vec%0d.valid_next", i), 64'(bus.mem0_valid), 64'(tbl[i].e_valid));
    end

    // starvation bound: twice in a row, proving the count restarts after the pipeline wins
    do_reset();
    for (int r = 0; r < 2; r++) begin
      idle_in();
      ex_mem(1'b1, 1'b0, 2'd2, 32'h2000);
      bus.req_valid = 2'b11;
      edge_step();
      bus.ex_valid = 1'b0;
      count_until_pipe($sformatf("starve%0d", r), STARVE_MAX, 30'h800);
    end

    // dcache busy: no grants, stage stalls, starvation count frozen
    idle_in();
    ex_mem(1'b1, 1'b0, 2'd2, 32'h3000);
    bus.req_valid = 2'b01;
    edge_step();
    bus.ex_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.dc_ready = (c < 2);
      @(negedge clk);
      chk($sformatf("busy%0d.grant", c), 64'(bus.req_grant), (c < 2) ? 64'd1 : 64'd0);
      chk($sformatf("busy%0d.dc_read", c), 64'(bus.mem0_dc_read), (c < 2) ? 64'd1 : 64'd0);
      chk($sformatf("busy%0d.stall", c), 64'(bus.mem0_stall), 64'd1);
      edge_step();
    end
    bus.dc_ready  = 1'b1;
    bus.req_valid = 2'b11;
    count_until_pipe("busy_resume", STARVE_MAX - 2, 30'hC00);

    // memory1 stall, then flush on top of it
    idle_in();
    ex_mem(1'b1, 1'b0, 2'd2, 32'h4000);
    edge_step();
    idle_in();
    bus.mem1_stall = 1'b1;
    @(negedge clk);
    chk("m1stall.stall", 64'(bus.mem0_stall), 64'd1);
    chk("m1stall.dc_read", 64'(bus.mem0_dc_read), 64'd0);
    edge_step();
    chk("m1stall.held", 64'(bus.mem0_valid), 64'd1);
    bus.mem0_flush = 1'b1;
    ex_mem(1'b1, 1'b0, 2'd2, 32'h4400);
    @(negedge clk);
    chk("flush.stall", 64'(bus.mem0_stall), 64'd0);
    edge_step();
    chk("flush.valid_next", 64'(bus.mem0_valid), 64'd0);

    // misaligned word store
    idle_in();
    ex_mem(1'b0, 1'b1, 2'd2, 32'h1002);
    edge_step();
    idle_in();
    @(negedge clk);
`ifdef MEM0_MISALIGN_EN
    chk("misal.exc", 64'(bus.mem0_exc), 64'd1);
    chk("misal.cause", 64'(bus.mem0_exc_cause), 64'(ECAUSE_STORE_MISALIGN));
    chk("misal.dc_read", 64'(bus.mem0_dc_read), 64'd0);
    chk("misal.stall", 64'(bus.mem0_stall), 64'd0);
`else
    chk("misal.exc", 64'(bus.mem0_exc), 64'd0);
    chk("misal.dc_read", 64'(bus.mem0_dc_read), 64'd1);
    chk("misal.dc_trans", 64'(bus.mem0_dc_trans), 64'd1);
    chk("misal.dc_addr", 64'(bus.mem0_dc_addr), 64'h400);
`endif
    edge_step();

    // randomized run against the model
    do_reset();
    m        = '{default: '0};
    m_rr     = 0;
    m_starve = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      random_cycle(cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_memory0_arb.md
Name: stage_memory0_arb

Overview:
Parametrised memory-stage-0 pipeline register and data-cache request arbiter, the successor to the current memory0 stage. Sits between execute and memory1. Arbitrates the dcache read port between NREQ internal physical-address requestors (memory1 refill, fetch1, page walker, ...) and the pipeline's own translated access. Uses round-robin among internal requestors, a bounded-starvation guarantee for the pipeline, dcache backpressure, flush, and misaligned-access exceptions.

Parameters:
NREQ, 2, number of internal dcache requestors; index 0 is memory1, 1 is fetch1; range 1..8.
PADDR_W, 27, internal requestor word-address width (bits [PADDR_W+1:2]); zero-extended to [31:2].
STARVE_MAX, 4, maximum consecutive cycles the pipeline access may lose arbitration; range 1..15.

Ports:
clk_core  in  1  core clock
reset_n  in  1  synchronous active-low reset
ex_valid, ex_exc, ex_exc_cause(ecause_t), ex_pc[31:2], ex_data0[31:0], ex_data1[31:0], ex_mem_read, ex_mem_write, ex_mem_extend, ex_mem_width[1:0], ex_wb_reg[4:0]  in  -  execute payload; data0 is address, data1 is store data
mem0_stall  out  1  backpressure to execute
mem0_flush  in  1  kill the held instruction
req_valid  in  NREQ  internal requestor valid
req_addr  in  NREQ*PADDR_W  packed; requestor i at [i*PADDR_W +: PADDR_W]
req_grant  out  NREQ  one-hot; the request is accepted this cycle
dc_ready  in  1  dcache can accept a read
mem0_dc_read, mem0_dc_trans  out  1  dcache read strobe; translate-enable
mem0_dc_asid  out  9  csr_satp[30:22]
mem0_dc_addr  out  30  dcache word address [31:2]
csr_satp  in  32  satp CSR
mem0_fwd_data  out  32  mem0_addr, forwarded to decode
mem0_valid, mem0_exc, mem0_exc_cause, mem0_pc, mem0_read, mem0_write, mem0_extend, mem0_width, mem0_addr, mem0_wdata, mem0_wb_reg  out  -  registered payload to memory1
mem1_stall  in  1  memory1 backpressure

Behaviour:
- Reset (reset_n=0 at a clk_core edge): all registered outputs go to 0, mem0_exc_cause to its zero encoding, rr_ptr=0, starve_cnt=0.
- need = mem0_valid & (mem0_read|mem0_write) & ~mem0_exc.
- Arbitration is combinational and only happens when dc_ready=1. When dc_ready=0: no grant, mem0_dc_read=0, counters hold.
- pipe_prio = (starve_cnt==STARVE_MAX). If need & pipe_prio, the pipeline wins.
- Otherwise the first valid requestor at or after rr_ptr (cyclic) wins. If none is valid and need=1, the pipeline wins.
- An internal win drives req_grant[i]=1, mem0_dc_read=1, mem0_dc_trans=0, and mem0_dc_addr = zero-extended req_addr[i]. Next rr_ptr = (i+1) mod NREQ.
- A pipeline win drives mem0_dc_read=1, mem0_dc_trans=1, mem0_dc_addr=mem0_addr[31:2]. It is suppressed (dc_read=0) while mem1_stall=1, so no read is issued for an access that cannot advance.
- pipe_win = the pipeline won arbitration with dc_ready=1 and mem1_stall=0.
- starve_cnt: cleared on pipe_win or when need=0. Incremented (saturating at STARVE_MAX) when need=1 and an internal requestor wins.
- mem0_stall = mem0_valid & ~mem0_flush & (mem1_stall | (need & ~pipe_win)).
- Register update, one-cycle latency: if mem0_flush, mem0_valid<=0, other payload don't-care. Else if ~mem0_stall, load the full ex_* payload (mem0_addr<=ex_data0, mem0_wdata<=ex_data1). Else hold.
- Flush has priority over stall and load. An instruction presented by execute on a flush cycle is dropped.
- Non-memory instructions (read=write=0) advance when mem1_stall=0 regardless of dc_ready.

Optional Feature:
MEM0_MISALIGN_EN defined:
- Misalignment is checked at load time: ex_valid & (read|write) & ~ex_exc & ((width==1 & ex_data0[0]) | (width==2 & ex_data0[1:0]!=0)).
- On a hit: mem0_exc<=1, mem0_exc_cause<=ECAUSE_LOAD_MISALIGN or ECAUSE_STORE_MISALIGN (write wins if both). The access then never requests the dcache.
Not defined: no check, ex_exc/ex_exc_cause pass through unchanged.

Decomposition:
- The ecause_t misalign encodings ECAUSE_LOAD_MISALIGN and ECAUSE_STORE_MISALIGN go in the shared defines.svh header.
- Sub-module rr_arbiter (parameter N): req, ptr -> one-hot grant plus index, pure combinational. The top level owns rr_ptr and starve_cnt.

Test Plan:
- Pipeline load, addr 0x1000, no internal requests, dc_ready=1 -> dc_read=1, trans=1, dc_addr=0x400, advances in 1 cycle.
- req_valid=2'b11 held, rr_ptr=0 -> grants alternate 01,10,01,...; pipeline load idle.
- Pipeline load with req_valid=2'b11 held, STARVE_MAX=4 -> 4 internal grants, then the pipeline wins on the 5th cycle and starve_cnt returns to 0.
- dc_ready=0 for 3 cycles with a load and req_valid=1 -> no grants, mem0_stall=1, starve_cnt unchanged.
- mem1_stall=1 with mem0_flush=1 -> mem0_valid=0 next cycle, mem0_stall=0 on the flush cycle.
- MEM0_MISALIGN_EN defined: store, width=2, addr 0x1002 -> mem0_exc=1, cause ECAUSE_STORE_MISALIGN, no dcache read. Macro not defined: the same store issues a read at dc_addr=0x400.
